// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IDLE/RUN control and the IF/ID pipeline register.
// Optional macro FETCH_JUMP_PREDECODE_EN redirects the PC to J-type targets at load time.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] pc,
    output logic        align_err,
    output logic [31:0] fetch_count
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic        r_ifid_valid;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc4;
    logic        r_align_err;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc4;
    logic [31:0] w_next_pc;
    logic        w_load;

    assign w_pc4  = r_pc + 32'd4;
    assign w_load = (r_state == S_RUN) && (!r_ifid_valid || id_ready) && !redirect_valid;

`ifdef FETCH_JUMP_PREDECODE_EN
    // J-type opcode: follow the target now so no bubble is spent waiting for a redirect
    assign w_next_pc = (imem_instr[31:26] == 6'b000010)
                     ? {w_pc4[31:28], imem_instr[25:0], 2'b00}
                     : w_pc4;
`else
    assign w_next_pc = w_pc4;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= fetch_en ? S_RUN : S_IDLE;
        end
    end

    // Redirect outranks everything except reset; the flush leaves the stale IF/ID fields in place
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_ifid_valid  <= 1'b0;
            r_ifid_instr  <= 32'd0;
            r_ifid_pc     <= 32'd0;
            r_ifid_pc4    <= 32'd0;
            r_fetch_count <= 32'd0;
        end else if (redirect_valid) begin
            r_pc         <= {redirect_pc[31:2], 2'b00};
            r_ifid_valid <= 1'b0;
        end else if (w_load) begin
            r_pc          <= w_next_pc;
            r_ifid_valid  <= 1'b1;
            r_ifid_instr  <= imem_instr;
            r_ifid_pc     <= r_pc;
            r_ifid_pc4    <= w_pc4;
            r_fetch_count <= r_fetch_count + 32'd1;
        end else if (r_ifid_valid && id_ready) begin
            r_ifid_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_align_err <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            r_align_err <= 1'b1;
        end
    end

    assign imem_addr   = {2'b00, r_pc[31:2]};
    assign pc          = r_pc;
    assign ifid_valid  = r_ifid_valid;
    assign ifid_instr  = r_ifid_instr;
    assign ifid_pc     = r_ifid_pc;
    assign ifid_pc4    = r_ifid_pc4;
    assign align_err   = r_align_err;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected IF/ID loads are queued as stimulus is driven.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        jump_mode;

    logic [31:0] imem_addr, imem_instr;
    logic        ifid_valid, align_err;
    logic [31:0] ifid_instr, ifid_pc, ifid_pc4, pc, fetch_count;

    logic [31:0] w_imem_addr, w_imem_instr;
    logic        w_ifid_valid, w_align_err;
    logic [31:0] w_ifid_instr, w_ifid_pc, w_ifid_pc4, w_pc, w_fetch_count;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    // Instruction memory: word index * 0x11, with an optional J at pc 0x10
    assign imem_instr   = (jump_mode && imem_addr == 32'd4) ? 32'h0800_0020 : imem_addr * 32'h11;
    assign w_imem_instr = w_imem_addr * 32'h11;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
        .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .pc(pc),
        .align_err(align_err), .fetch_count(fetch_count)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .ifid_valid(w_ifid_valid), .ifid_instr(w_ifid_instr),
        .ifid_pc(w_ifid_pc), .ifid_pc4(w_ifid_pc4), .pc(w_pc),
        .align_err(w_align_err), .fetch_count(w_fetch_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then start running; the first load happens on the edge after the RUN transition
    task automatic restart();
        rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; id_ready = 1'b1;
        tick();
        rst_n = 1'b1; fetch_en = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        id_ready = 1'b1; jump_mode = 1'b0;
        tick(); tick();
        vectors++; if (pc !== 32'd0) begin miscompares++; $display("FAIL reset_pc: got %h want %h", pc, 32'd0); end
        vectors++; if (imem_addr !== 32'd0) begin miscompares++; $display("FAIL reset_imem_addr: got %h want %h", imem_addr, 32'd0); end
        vectors++; if (ifid_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", ifid_valid); end
        vectors++; if ({ifid_instr, ifid_pc, ifid_pc4} !== 96'd0) begin miscompares++; $display("FAIL reset_ifid: got %h %h %h want 0", ifid_instr, ifid_pc, ifid_pc4); end
        vectors++; if (align_err !== 1'b0) begin miscompares++; $display("FAIL reset_align: got %b want 0", align_err); end
        vectors++; if (fetch_count !== 32'd0) begin miscompares++; $display("FAIL reset_count: got %h want 0", fetch_count); end
        vectors++; if (w_pc !== 32'hFFFF_FFF8) begin miscompares++; $display("FAIL reset_pc_param: got %h want FFFFFFF8", w_pc); end
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        rst_n = 1'b1;
        tick();
        vectors++; if (ifid_valid !== 1'b0) begin miscompares++; $display("FAIL first_edge_no_load: got %b want 0", ifid_valid); end
    endtask

    task automatic test_sequential();
        restart();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'(i * 4));
            tick();
            exp_pc = exp_q.pop_front();
            vectors++;
            if (ifid_valid !== 1'b1 || ifid_pc !== exp_pc || ifid_instr !== (exp_pc >> 2) * 32'h11 || ifid_pc4 !== exp_pc + 32'd4) begin
                miscompares++;
                $display("FAIL seq_load%0d: got v=%b pc=%h instr=%h pc4=%h want pc=%h instr=%h", i, ifid_valid, ifid_pc, ifid_instr, ifid_pc4, exp_pc, (exp_pc >> 2) * 32'h11);
            end
        end
        vectors++; if (fetch_count !== 32'd4) begin miscompares++; $display("FAIL seq_count: got %0d want 4", fetch_count); end
        vectors++; if (pc !== 32'd16 || imem_addr !== 32'd4) begin miscompares++; $display("FAIL seq_pc: got pc=%h addr=%h want 10/4", pc, imem_addr); end
    endtask

    task automatic test_stall();
        restart();
        tick(); tick(); tick();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (pc !== 32'd12 || ifid_pc !== 32'd8 || ifid_valid !== 1'b1 || fetch_count !== 32'd3) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got pc=%h ifid_pc=%h v=%b cnt=%0d want 0c/08/1/3", i, pc, ifid_pc, ifid_valid, fetch_count);
            end
        end
        id_ready = 1'b1;
        exp_q.push_back(32'd12);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++;
        if (ifid_pc !== exp_pc || ifid_instr !== 32'h33 || fetch_count !== 32'd4) begin
            miscompares++;
            $display("FAIL stall_release: got pc=%h instr=%h cnt=%0d want %h/33/4", ifid_pc, ifid_instr, fetch_count, exp_pc);
        end
    endtask

    task automatic test_redirect();
        id_ready = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        vectors++;
        if (ifid_valid !== 1'b0 || pc !== 32'h40 || fetch_count !== 32'd4 || align_err !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_flush: got v=%b pc=%h cnt=%0d ae=%b want 0/40/4/0", ifid_valid, pc, fetch_count, align_err);
        end
        redirect_valid = 1'b0; id_ready = 1'b1;
        exp_q.push_back(32'h40);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++;
        if (ifid_valid !== 1'b1 || ifid_pc !== exp_pc || ifid_instr !== 32'h110 || fetch_count !== 32'd5) begin
            miscompares++;
            $display("FAIL redirect_target: got v=%b pc=%h instr=%h cnt=%0d want 1/%h/110/5", ifid_valid, ifid_pc, ifid_instr, fetch_count, exp_pc);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        tick();
        vectors++;
        if (pc !== 32'h40 || align_err !== 1'b1 || ifid_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL misaligned: got pc=%h ae=%b v=%b want 40/1/0", pc, align_err, ifid_valid);
        end
        redirect_valid = 1'b0;
        tick(); tick(); tick();
        vectors++;
        if (align_err !== 1'b1 || ifid_pc !== 32'h48) begin
            miscompares++;
            $display("FAIL align_sticky: got ae=%b ifid_pc=%h want 1/48", align_err, ifid_pc);
        end
        rst_n = 1'b0;
        tick();
        vectors++; if (align_err !== 1'b0) begin miscompares++; $display("FAIL align_clear: got %b want 0", align_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_reset_midstall();
        restart();
        tick();
        id_ready = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        rst_n = 1'b0;
        tick();
        redirect_valid = 1'b0; rst_n = 1'b1; id_ready = 1'b1;
        tick();
        vectors++;
        if (ifid_valid !== 1'b0 || pc !== 32'd0 || fetch_count !== 32'd0) begin
            miscompares++;
            $display("FAIL midstall_reset: got v=%b pc=%h cnt=%0d want 0/0/0", ifid_valid, pc, fetch_count);
        end
        tick();
        vectors++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'd0) begin
            miscompares++;
            $display("FAIL midstall_first_load: got v=%b pc=%h want 1/0", ifid_valid, ifid_pc);
        end
    endtask

    task automatic test_idle();
        restart();
        tick();
        fetch_en = 1'b0;
        tick();
        tick();
        vectors++;
        if (ifid_valid !== 1'b0 || pc !== 32'd8 || ifid_pc !== 32'd4 || fetch_count !== 32'd2) begin
            miscompares++;
            $display("FAIL idle_drain: got v=%b pc=%h ifid_pc=%h cnt=%0d want 0/8/4/2", ifid_valid, pc, ifid_pc, fetch_count);
        end
        tick(); tick();
        vectors++;
        if (pc !== 32'd8 || fetch_count !== 32'd2) begin
            miscompares++;
            $display("FAIL idle_hold: got pc=%h cnt=%0d want 8/2", pc, fetch_count);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] wpc;
        restart();
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            wpc = exp_q.pop_front();
            vectors++;
            if (w_ifid_pc !== wpc || w_ifid_pc4 !== wpc + 32'd4 || w_ifid_instr !== {2'b00, wpc[31:2]} * 32'h11) begin
                miscompares++;
                $display("FAIL wrap%0d: got pc=%h pc4=%h instr=%h want pc=%h", i, w_ifid_pc, w_ifid_pc4, w_ifid_instr, wpc);
            end
        end
    endtask

    task automatic test_jump();
        jump_mode = 1'b1;
        restart();
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
`ifdef FETCH_JUMP_PREDECODE_EN
        exp_q.push_back(32'h80);
`else
        exp_q.push_back(32'h14);
`endif
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_pc = exp_q.pop_front();
            vectors++;
            if (ifid_valid !== 1'b1 || ifid_pc !== exp_pc) begin
                miscompares++;
                $display("FAIL jump_seq%0d: got v=%b pc=%h want 1/%h", i, ifid_valid, ifid_pc, exp_pc);
            end
            if (i == 4) begin
                vectors++;
                if (ifid_instr !== 32'h0800_0020) begin
                    miscompares++;
                    $display("FAIL jump_instr: got %h want 08000020", ifid_instr);
                end
            end
        end
        jump_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_reset_midstall();
        test_idle();
        test_wrap();
        test_jump();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
